// File: rtl/lfsr_pkg.sv
// Shared definitions for the 5-bit Galois LFSR sequencer: state encoding,
// tap mask and the single-step next-state function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LFSR5_TAPS = 5'b00100;
  localparam logic [4:0] LFSR5_ZERO = 5'b00000;
  localparam logic [4:0] LFSR5_INIT = 5'b00001;

  // x^5+x^2+1: rotate left, and fold the bit leaving the top back into bit 2.
  function automatic logic [4:0] lfsr5_step(input logic [4:0] q);
    return {q[3:0], q[4]} ^ (q[4] ? LFSR5_TAPS : LFSR5_ZERO);
  endfunction

endpackage

// File: rtl/lfsr5_core.sv
// 5-bit Galois LFSR register with a parallel load and a step enable.
module lfsr5_core
  import lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       load,
  input  logic [4:0] seed,
  input  logic       step,
  output logic [4:0] q
);

  logic [4:0] r_q;
  logic [4:0] w_q_nxt;

  always_comb begin
    w_q_nxt = r_q;
    if (load) begin
      w_q_nxt = seed;
    end else if (step) begin
      w_q_nxt = lfsr5_step(r_q);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_q <= LFSR5_INIT;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/lfsr5_seq_ctrl.sv
// Sequencer that runs the 5-bit LFSR for a programmed number of beats from a
// programmed seed and streams each state over a valid/ready handshake.
module lfsr5_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start_i,
  input  logic [4:0]       seed_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             abort_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [4:0]       out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remaining_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_load;
  logic             w_step;
  logic [4:0]       w_q;

  lfsr5_core u_core (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (w_load),
    .seed  (seed_i),
    .step  (w_step),
    .q     (w_q)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_err_nxt       = 1'b0;
    w_load          = 1'b0;
    w_step          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          // A zero seed would lock the LFSR at zero, so it is rejected outright.
          if (seed_i == LFSR5_ZERO) begin
            w_err_nxt = 1'b1;
          end else begin
            w_load          = 1'b1;
            w_remaining_nxt = count_i;
            w_state_nxt     = (count_i == '0) ? ST_DONE : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Abort wins over a same-cycle handshake; that beat is not consumed.
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (out_ready_i) begin
          w_step          = 1'b1;
          w_remaining_nxt = r_remaining - CNT_ONE;
          if (r_remaining == CNT_ONE) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign out_valid_o = (r_state == ST_RUN);
  assign out_data_o  = w_q;
  assign out_last_o  = out_valid_o && (r_remaining == CNT_ONE);
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = (r_state == ST_DONE) && !abort_i;
  assign err_o       = r_err;

endmodule

// File: tb/tb_lfsr5_seq_ctrl.sv
// Self-checking bench for lfsr5_seq_ctrl: directed scenarios plus randomized
// runs checked against a polynomial-arithmetic reference of the LFSR.
module tb_lfsr5_seq_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             start_i = 1'b0;
  logic [4:0]       seed_i = '0;
  logic [CNT_W-1:0] count_i = '0;
  logic             abort_i = 1'b0;
  logic             out_ready_i = 1'b0;
  logic             out_valid_o;
  logic [4:0]       out_data_o;
  logic             out_last_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  lfsr5_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start_i     (start_i),
    .seed_i      (seed_i),
    .count_i     (count_i),
    .abort_i     (abort_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected LFSR contents, tracked across scenarios.
  logic [4:0] m_lfsr = 5'h01;

  // Observations gathered by collect().
  logic [4:0] c_beats[$];
  bit         c_lasts[$];
  int         c_done, c_err, c_busy, c_valid, c_hold_bad, c_last_cyc, c_done_cyc;
  bit         c_timeout;

  // Multiply by x modulo x^5+x^2+1 (0x25).
  function automatic logic [4:0] ref_next(input logic [4:0] v);
    int x;
    x = int'(v) * 2;
    if (x >= 32) x = x ^ 'h25;
    return 5'(x);
  endfunction

  function automatic logic [4:0] ref_advance(input logic [4:0] v, input int n);
    logic [4:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = ref_next(r);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [4:0] s, input int n);
    seed_i  = s;
    count_i = CNT_W'(n);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Drives ready (stalled for the first 'stall' cycles, then random at pct%)
  // and records every accepted beat until the block returns to idle.
  task automatic collect(input int stall, input int pct, input int budget);
    bit         prev_stall;
    logic [4:0] prev_d;
    logic       prev_l;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    c_beats.delete();
    c_lasts.delete();
    c_done = 0; c_err = 0; c_busy = 0; c_valid = 0; c_hold_bad = 0;
    c_last_cyc = -1; c_done_cyc = -1; c_timeout = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (prev_stall && (out_valid_o !== 1'b1 || out_data_o !== prev_d || out_last_o !== prev_l))
        c_hold_bad++;
      if (done_o) begin c_done++; c_done_cyc = cyc; end
      if (err_o) c_err++;
      if (out_valid_o) c_valid++;
      if (!busy_o) begin c_timeout = 1'b0; break; end
      c_busy++;
      out_ready_i = (cyc < stall) ? 1'b0 : (int'($urandom_range(99)) < pct);
      if (out_valid_o && out_ready_i) begin
        c_beats.push_back(out_data_o);
        c_lasts.push_back(out_last_o);
        c_last_cyc = cyc;
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_d = out_data_o;
      prev_l = out_last_o;
      tick();
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    n_checks++; if (out_data_o !== 5'h01) begin n_fail++; $display("FAIL reset_data: got %h expected 01", out_data_o); end
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || out_last_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b done=%b err=%b last=%b expected all 0", busy_o, done_o, err_o, out_last_o);
    end
    rst_b = 1'b1;
    tick();
    n_checks++; if (busy_o !== 1'b0 || out_data_o !== 5'h01) begin
      n_fail++; $display("FAIL post_reset_idle: busy=%b data=%h expected 0/01", busy_o, out_data_o);
    end
    m_lfsr = 5'h01;
  endtask

  task automatic test_basic();
    logic [4:0] exp_b[6];
    exp_b = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h05};
    launch(5'h01, 6);
    collect(0, 100, 100);
    n_checks++; if (c_timeout) begin n_fail++; $display("FAIL basic_timeout: run did not return to idle"); end
    n_checks++; if (c_beats.size() != 6) begin n_fail++; $display("FAIL basic_count: got %0d beats expected 6", c_beats.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < c_beats.size()) begin
        n_checks++; if (c_beats[k] !== exp_b[k]) begin n_fail++; $display("FAIL basic_beat%0d: got %h expected %h", k, c_beats[k], exp_b[k]); end
        n_checks++; if (c_lasts[k] !== (k == 5)) begin n_fail++; $display("FAIL basic_last%0d: got %b expected %b", k, c_lasts[k], (k == 5)); end
      end
    end
    n_checks++; if (c_done != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", c_done); end
    n_checks++; if (c_done_cyc != c_last_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing: done at %0d expected %0d", c_done_cyc, c_last_cyc + 1); end
    m_lfsr = ref_advance(5'h01, 6);
    n_checks++; if (out_data_o !== m_lfsr) begin n_fail++; $display("FAIL basic_final_lfsr: got %h expected %h", out_data_o, m_lfsr); end
  endtask

  task automatic test_backpressure();
    logic [4:0] v;
    launch(5'h01, 3);
    collect(4, 100, 100);
    n_checks++; if (c_timeout) begin n_fail++; $display("FAIL bp_timeout: run did not return to idle"); end
    n_checks++; if (c_hold_bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d stall cycles changed outputs expected 0", c_hold_bad); end
    n_checks++; if (c_beats.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d beats expected 3", c_beats.size()); end
    n_checks++; if (c_busy != 8) begin n_fail++; $display("FAIL bp_busy_cycles: got %0d expected 8", c_busy); end
    v = 5'h01;
    for (int k = 0; k < 3; k++) begin
      if (k < c_beats.size()) begin
        n_checks++; if (c_beats[k] !== v) begin n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", k, c_beats[k], v); end
      end
      v = ref_next(v);
    end
    n_checks++; if (c_done != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", c_done); end
    m_lfsr = v;
  endtask

  task automatic test_zero_seed();
    launch(5'h00, 5);
    collect(0, 100, 20);
    n_checks++; if (c_err != 1) begin n_fail++; $display("FAIL zseed_err: got %0d pulses expected 1", c_err); end
    n_checks++; if (c_busy != 0 || c_valid != 0) begin n_fail++; $display("FAIL zseed_idle: busy=%0d valid=%0d expected 0/0", c_busy, c_valid); end
    n_checks++; if (out_data_o !== m_lfsr) begin n_fail++; $display("FAIL zseed_lfsr: got %h expected %h", out_data_o, m_lfsr); end
    tick();
    n_checks++; if (err_o !== 1'b0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL zseed_single_pulse: err=%b valid=%b expected 0/0", err_o, out_valid_o); end
  endtask

  task automatic test_zero_count();
    launch(5'h0A, 0);
    collect(0, 100, 20);
    n_checks++; if (c_valid != 0) begin n_fail++; $display("FAIL zcnt_valid: got %0d valid cycles expected 0", c_valid); end
    n_checks++; if (c_done != 1) begin n_fail++; $display("FAIL zcnt_done: got %0d pulses expected 1", c_done); end
    n_checks++; if (c_busy != 1) begin n_fail++; $display("FAIL zcnt_busy: got %0d cycles expected 1", c_busy); end
    m_lfsr = 5'h0A;
    n_checks++; if (out_data_o !== m_lfsr) begin n_fail++; $display("FAIL zcnt_lfsr: got %h expected %h", out_data_o, m_lfsr); end
  endtask

  task automatic test_full_period();
    bit         seen[32];
    int         dup;
    logic [4:0] v;
    launch(5'h01, 32);
    collect(0, 70, 600);
    n_checks++; if (c_timeout) begin n_fail++; $display("FAIL full_timeout: run did not return to idle"); end
    n_checks++; if (c_beats.size() != 32) begin n_fail++; $display("FAIL full_count: got %0d beats expected 32", c_beats.size()); end
    dup = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    v = 5'h01;
    for (int k = 0; k < 32; k++) begin
      if (k < c_beats.size()) begin
        n_checks++; if (c_beats[k] !== v) begin n_fail++; $display("FAIL full_beat%0d: got %h expected %h", k, c_beats[k], v); end
        if (k < 31) begin
          if (seen[c_beats[k]] || c_beats[k] == 5'h00) dup++;
          seen[c_beats[k]] = 1'b1;
        end
      end
      v = ref_next(v);
    end
    n_checks++; if (dup != 0) begin n_fail++; $display("FAIL full_distinct: %0d repeated or zero values expected 0", dup); end
    if (c_beats.size() == 32) begin
      n_checks++; if (c_beats[31] !== 5'h01 || c_lasts[31] !== 1'b1) begin
        n_fail++; $display("FAIL full_wrap: beat32=%h last=%b expected 01/1", c_beats[31], c_lasts[31]);
      end
    end
    m_lfsr = v;
  endtask

  task automatic test_abort();
    logic [4:0] v;
    launch(5'h01, 10);
    out_ready_i = 1'b1;
    repeat (3) tick();
    n_checks++; if (out_data_o !== 5'h08 || out_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre: data=%h valid=%b expected 08/1", out_data_o, out_valid_o);
    end
    abort_i = 1'b1;
    #1;
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_done_now: got %b expected 0", done_o); end
    tick();
    abort_i = 1'b0;
    out_ready_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b valid=%b expected 0/0", busy_o, out_valid_o);
    end
    n_checks++; if (out_data_o !== 5'h08) begin n_fail++; $display("FAIL abort_lfsr: got %h expected 08", out_data_o); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_done%0d: got %b expected 0", i, done_o); end
      tick();
    end
    launch(5'h13, 4);
    collect(0, 60, 200);
    n_checks++; if (c_beats.size() != 4 || c_done != 1) begin
      n_fail++; $display("FAIL abort_restart: beats=%0d done=%0d expected 4/1", c_beats.size(), c_done);
    end
    v = 5'h13;
    for (int k = 0; k < 4; k++) begin
      if (k < c_beats.size()) begin
        n_checks++; if (c_beats[k] !== v) begin n_fail++; $display("FAIL abort_restart_beat%0d: got %h expected %h", k, c_beats[k], v); end
      end
      v = ref_next(v);
    end
    m_lfsr = v;
  endtask

  task automatic test_async_reset();
    launch(5'h07, 20);
    out_ready_i = 1'b1;
    tick(); tick();
    #2 rst_b = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== 5'h01 || done_o !== 1'b0 || out_last_o !== 1'b0) begin
      n_fail++; $display("FAIL areset: busy=%b valid=%b data=%h done=%b last=%b expected 0/0/01/0/0",
                         busy_o, out_valid_o, out_data_o, done_o, out_last_o);
    end
    out_ready_i = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL areset_after: busy=%b done=%b expected 0/0", busy_o, done_o); end
    m_lfsr = 5'h01;
  endtask

  task automatic test_random();
    logic [4:0] s;
    logic [4:0] v;
    int         n;
    int         pct;
    int         bad;
    for (int it = 0; it < 8; it++) begin
      s   = 5'($urandom_range(31, 1));
      n   = int'($urandom_range(45, 1));
      pct = int'($urandom_range(100, 30));
      launch(s, n);
      collect(int'($urandom_range(3)), pct, n * 40 + 50);
      n_checks++; if (c_timeout || c_beats.size() != n || c_done != 1 || c_hold_bad != 0) begin
        n_fail++; $display("FAIL rand%0d_run: beats=%0d done=%0d hold_bad=%0d timeout=%b expected %0d/1/0/0",
                           it, c_beats.size(), c_done, c_hold_bad, c_timeout, n);
      end
      bad = 0;
      v = s;
      for (int k = 0; k < n; k++) begin
        if (k < c_beats.size()) begin
          if (c_beats[k] !== v || c_lasts[k] !== (k == n - 1)) bad++;
        end
        v = ref_next(v);
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_beats: %0d wrong beats expected 0 (seed %h count %0d)", it, bad, s, n); end
      m_lfsr = v;
      n_checks++; if (out_data_o !== m_lfsr) begin n_fail++; $display("FAIL rand%0d_lfsr: got %h expected %h", it, out_data_o, m_lfsr); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_seed();
    test_zero_count();
    test_full_period();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
